// File: rtl/core_pkg.sv
// core_pkg: shared core typedefs used by the execute-stage units.
//   mul_op_e    - multiply/divide operation selector from the decoded ctrl bus
//   reg_add_e   - destination register tag (x0..x31, NO_REG when no write)
//   div_state_e - state encoding of the iterative divider
//   DIV_ITER    - quotient bits produced by the divider, one per cycle
//   neg_if()    - conditional two's complement negation helper
package core_pkg;

  typedef enum logic [3:0] {
    MUL_MUL    = 4'd0,
    MUL_MULH   = 4'd1,
    MUL_MULHSU = 4'd2,
    MUL_MULHU  = 4'd3,
    MUL_DIV    = 4'd4,
    MUL_DIVU   = 4'd5,
    MUL_REM    = 4'd6,
    MUL_REMU   = 4'd7,
    MUL_NONE   = 4'd15
  } mul_op_e;

  typedef enum logic [5:0] {
    REG_X0 = 6'd0, REG_X1, REG_X2, REG_X3, REG_X4, REG_X5, REG_X6, REG_X7,
    REG_X8, REG_X9, REG_X10, REG_X11, REG_X12, REG_X13, REG_X14, REG_X15,
    REG_X16, REG_X17, REG_X18, REG_X19, REG_X20, REG_X21, REG_X22, REG_X23,
    REG_X24, REG_X25, REG_X26, REG_X27, REG_X28, REG_X29, REG_X30, REG_X31,
    NO_REG = 6'd63
  } reg_add_e;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_ITER = 32;

  // Two's complement negate when n is set (wraps modulo 2^32).
  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] x);
    return n ? -x : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
//   clk_i/rst_i         clock (rising) and asynchronous active-high reset
//   valid_i/ready_o     request handshake; ready_o high only while idle
//   op_i, rs1_i, rs2_i  operation, dividend, divisor (sampled on accept only)
//   rd_i                destination tag carried through to rd_o
//   kill_i              pipeline flush: drops any operation in flight
//   valid_o/ready_i     result handshake; result_o/rd_o held under backpressure
//   result_o, rd_o      quotient or remainder, and its destination tag
module div_unit
  import core_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  mul_op_e         op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  reg_add_e        rd_i,
  input  logic            kill_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output reg_add_e        rd_o
);

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  mul_op_e         op_q, op_d;
  reg_add_e        rd_q, rd_d;
  logic            sgn_quo_q, sgn_quo_d;
  logic            sgn_rem_q, sgn_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            is_div_op, in_signed, in_rem, div_zero, ovf, accept;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;
  logic [XLEN:0]   rem_sh, rem_step;
  logic [XLEN-1:0] quo_step;
  logic            fits, out_rem;

  // Request decode, operand magnitudes and one restoring division step.
  always_comb begin
    is_div_op = op_i inside {MUL_DIV, MUL_DIVU, MUL_REM, MUL_REMU};
    in_signed = (op_i == MUL_DIV) || (op_i == MUL_REM);
    in_rem    = (op_i == MUL_REM) || (op_i == MUL_REMU);
    div_zero  = (rs2_i == '0);
    ovf       = in_signed && (rs1_i == INT_MIN) && (&rs2_i);
    accept    = valid_i && (state_q == DIV_IDLE) && !kill_i && is_div_op;
    abs_a     = (in_signed && rs1_i[XLEN-1]) ? -rs1_i : rs1_i;
    abs_b     = (in_signed && rs2_i[XLEN-1]) ? -rs2_i : rs2_i;
    // Only reached for div-by-zero or signed overflow.
    if (div_zero) begin
      fast_res = in_rem ? rs1_i : '1;
    end else begin
      fast_res = in_rem ? '0 : INT_MIN;
    end
    // Shift the next dividend bit into the remainder, subtract if it fits.
    rem_sh   = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    fits     = (rem_sh >= {1'b0, dvsr_q});
    rem_step = fits ? (rem_sh - {1'b0, dvsr_q}) : rem_sh;
    quo_step = {quo_q[XLEN-2:0], fits};
    out_rem  = (op_q == MUL_REM) || (op_q == MUL_REMU);
  end

  // Next-state and datapath update for the divider FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    op_d      = op_q;
    rd_d      = rd_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    result_d  = result_q;
    if (kill_i) begin
      state_d  = DIV_IDLE;
      cnt_d    = 6'd0;
      rd_d     = NO_REG;
      result_d = '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (accept) begin
            op_d = op_i;
            rd_d = rd_i;
            if (FAST_SPEC && (div_zero || ovf)) begin
              state_d  = DIV_DONE;
              result_d = fast_res;
            end else begin
              state_d   = DIV_CALC;
              cnt_d     = 6'd0;
              quo_d     = abs_a;
              rem_d     = '0;
              dvsr_d    = abs_b;
              // A zero divisor must yield all-ones, so never negate it.
              sgn_quo_d = in_signed && (rs1_i[XLEN-1] ^ rs2_i[XLEN-1]) && !div_zero;
              sgn_rem_d = in_signed && rs1_i[XLEN-1];
            end
          end else begin
            state_d = DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem_d = rem_step;
          quo_d = quo_step;
          if (cnt_q == 6'(DIV_ITER - 1)) begin
            state_d  = DIV_DONE;
            cnt_d    = 6'd0;
            // Sign fixup folded into the last step so DONE presents the result.
            result_d = out_rem ? neg_if(sgn_rem_q, rem_step[XLEN-1:0])
                               : neg_if(sgn_quo_q, quo_step);
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
        DIV_DONE: begin
          if (ready_i) begin
            state_d  = DIV_IDLE;
            rd_d     = NO_REG;
            result_d = '0;
          end else begin
            state_d = DIV_DONE;
          end
        end
        default: begin
          state_d  = DIV_IDLE;
          rd_d     = NO_REG;
          result_d = '0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= 6'd0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvsr_q    <= '0;
      op_q      <= MUL_NONE;
      rd_q      <= NO_REG;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvsr_q    <= dvsr_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      result_q  <= result_d;
    end
  end

  assign ready_o  = (state_q == DIV_IDLE);
  assign valid_o  = (state_q == DIV_DONE);
  assign result_o = result_q;
  assign rd_o     = rd_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit (directed table, corner
// sequences for backpressure/kill/reset, and random ops against a model).
module tb_div_unit;
  import core_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  mul_op_e     op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  reg_add_e    rd_i;
  logic        kill_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  reg_add_e    rd_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  div_unit #(.XLEN(32), .FAST_SPEC(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .kill_i(kill_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    mul_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // RISC-V M semantics from plain arithmetic, with the two special cases.
  function automatic logic [31:0] model(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (op)
      MUL_DIV:  if (b == 32'd0) return 32'hFFFFFFFF;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                else return 32'(sa / sb);
      MUL_REM:  if (b == 32'd0) return a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
                else return 32'(sa % sb);
      MUL_DIVU: if (b == 32'd0) return 32'hFFFFFFFF; else return a / b;
      MUL_REMU: if (b == 32'd0) return a; else return a % b;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input mul_op_e op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == MUL_DIV) || (op == MUL_REM);
    if (b == 32'd0 || (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    else return 33;
  endfunction

  // Issue one op with ready_i high; measure edges from accept to valid_o.
  task automatic run_op(input mul_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] tag, output logic [31:0] res, output int lat,
                        output logic [5:0] rdo);
    op_i = op; rs1_i = a; rs2_i = b; rd_i = reg_add_e'(tag); valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    rs1_i = $urandom;
    rs2_i = $urandom;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    res = result_o;
    rdo = rd_o;
    @(posedge clk_i); #1;
  endtask

  logic [31:0] res, held_res;
  logic [5:0]  rdo, held_rd;
  int          lat, vcount;
  mul_op_e     rop;
  logic [31:0] ra, rb;
  int          sel;

  initial begin
    rst_i = 1'b1; valid_i = 1'b0; op_i = MUL_NONE; rs1_i = 32'd0; rs2_i = 32'd0;
    rd_i = NO_REG; kill_i = 1'b0; ready_i = 1'b1;
    #1;
    chk("reset_valid", {31'd0, valid_o}, 32'd0);
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_rd", {26'd0, rd_o}, 32'd63);
    chk("reset_result", result_o, 32'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(posedge clk_i); #1;

    tbl[0]  = '{MUL_DIV,  32'd100,        32'd7,          32'd14,         33};
    tbl[1]  = '{MUL_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   33};
    tbl[2]  = '{MUL_DIVU, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   1};
    tbl[3]  = '{MUL_REMU, 32'h00001234,   32'd0,          32'h00001234,   1};
    tbl[4]  = '{MUL_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
    tbl[5]  = '{MUL_REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1};
    tbl[6]  = '{MUL_DIVU, 32'hFFFFFFFE,   32'd3,          32'h55555554,   33};
    tbl[7]  = '{MUL_DIV,  32'd9,          32'hFFFFFFFD,   32'hFFFFFFFD,   33};
    tbl[8]  = '{MUL_DIV,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFFF,   1};
    tbl[9]  = '{MUL_REM,  32'hFFFFFFF9,   32'd0,          32'hFFFFFFF9,   1};
    tbl[10] = '{MUL_REMU, 32'd7,          32'hFFFFFFFF,   32'd7,          33};
    tbl[11] = '{MUL_DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         33};
    tbl[12] = '{MUL_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          33};

    for (int i = 0; i < 13; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 6'(i + 1), res, lat, rdo);
      chk($sformatf("tbl%0d_result", i), res, tbl[i].exp);
      chk($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      chk($sformatf("tbl%0d_rd", i), {26'd0, rdo}, 32'(i + 1));
      chk($sformatf("tbl%0d_idle", i), {30'd0, valid_o, ready_o}, 32'd1);
    end

    // Backpressure: result and tag held; no accept while in DONE.
    ready_i = 1'b0;
    op_i = MUL_DIVU; rs1_i = 32'hFFFFFFFE; rs2_i = 32'd3; rd_i = REG_X20; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd33);
    chk("bp_result", result_o, 32'h55555554);
    held_res = result_o;
    held_rd = rd_o;
    op_i = MUL_DIVU; rs1_i = 32'd10; rs2_i = 32'd0; rd_i = REG_X5; valid_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      chk($sformatf("bp_hold_valid%0d", k), {31'd0, valid_o}, 32'd1);
      chk($sformatf("bp_hold_result%0d", k), result_o, held_res);
      chk($sformatf("bp_hold_rd%0d", k), {26'd0, rd_o}, 32'd20);
    end
    chk("bp_rd_latched", {26'd0, held_rd}, 32'd20);
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("bp_handshake_idle", {30'd0, valid_o, ready_o}, 32'd1);
    @(posedge clk_i); #1;
    chk("bp_no_second_result", {31'd0, valid_o}, 32'd0);

    // kill_i beats valid_i in IDLE.
    op_i = MUL_DIV; rs1_i = 32'd5; rs2_i = 32'd0; rd_i = REG_X3; valid_i = 1'b1; kill_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    chk("kill_vs_valid", {30'd0, valid_o, ready_o}, 32'd1);

    // kill_i on the 10th CALC cycle.
    op_i = MUL_DIV; rs1_i = 32'd1000; rs2_i = 32'd3; rd_i = REG_X9; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    chk("kill_valid", {31'd0, valid_o}, 32'd0);
    chk("kill_ready", {31'd0, ready_o}, 32'd1);
    chk("kill_rd", {26'd0, rd_o}, 32'd63);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk_i); #1;
      if (valid_o) vcount++;
    end
    chk("kill_no_result", 32'(vcount), 32'd0);
    run_op(MUL_DIV, 32'd9, 32'hFFFFFFFD, 6'd11, res, lat, rdo);
    chk("after_kill_result", res, 32'hFFFFFFFD);
    chk("after_kill_latency", 32'(lat), 32'd33);

    // Reset mid-CALC, then a non-divide op must be ignored.
    op_i = MUL_REMU; rs1_i = 32'd77; rs2_i = 32'd5; rd_i = REG_X7; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_ready", {31'd0, ready_o}, 32'd1);
    chk("midrst_rd", {26'd0, rd_o}, 32'd63);
    @(posedge clk_i); #1 rst_i = 1'b0;
    op_i = MUL_MUL; rs1_i = 32'd5; rs2_i = 32'd0; rd_i = REG_X4; valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      chk($sformatf("mul_ignored%0d", k), {30'd0, valid_o, ready_o}, 32'd1);
    end
    valid_i = 1'b0;

    // Random ops against the model.
    for (int n = 0; n < 40; n++) begin
      rop = mul_op_e'(4'(4 + $urandom_range(0, 3)));
      sel = $urandom_range(0, 7);
      ra = $urandom;
      rb = $urandom;
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 20));
      else if (sel == 3) rb = -32'($urandom_range(1, 20));
      else ra = ra;
      run_op(rop, ra, rb, 6'(n % 32), res, lat, rdo);
      chk($sformatf("rnd%0d_%s_%h_%h", n, rop.name(), ra, rb), res, model(rop, ra, rb));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(model_lat(rop, ra, rb)));
      chk($sformatf("rnd%0d_rd", n), {26'd0, rdo}, 32'(n % 32));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
